// File: rtl/context_hazard_ctrl_pkg.sv
// context_hazard_ctrl_pkg: shared widths, JPEG-LS init constants, FSM states and pipeline stage record
package context_hazard_ctrl_pkg;
  localparam int Q_length = 9;
  localparam int A_length = 16;
  localparam int NUM_CTX = 365;
  localparam logic [A_length-1:0] A_INIT = 16'd4;
  localparam logic [A_length-1:0] B_INIT = '0;
  localparam logic [A_length-1:0] C_INIT = '0;
  localparam logic [A_length-1:0] NN_INIT = '0;
  localparam logic [A_length-1:0] N_INIT = 16'd1;
  typedef enum logic [1:0] {IDLE, INIT, RUN, DRAIN} state_t;
  typedef struct packed {
    logic valid;
    logic [Q_length-1:0] q;
    logic needs_upd;
  } stage_t;
endpackage

// File: rtl/context_hazard_ctrl_if.sv
// context_hazard_ctrl_if: issue handshake, context-memory port and mux-control signals
interface context_hazard_ctrl_if;
  import context_hazard_ctrl_pkg::*;
  logic start, frame_end, in_valid, in_ready, mem_rd_en, mem_wr_en, mem_wr_init;
  logic sel_feedback, use_updated, upd_capture_en, s4_valid, busy, done;
  logic [Q_length-1:0] in_Q, mem_rd_addr, mem_wr_addr;
  modport master(
    output start, frame_end, in_valid, in_Q,
    input in_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_init,
    input sel_feedback, use_updated, upd_capture_en, s4_valid, busy, done
  );
  modport slave(
    input start, frame_end, in_valid, in_Q,
    output in_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_init,
    output sel_feedback, use_updated, upd_capture_en, s4_valid, busy, done
  );
endinterface

// File: rtl/context_hazard_ctrl_ctx_stage_tracker.sv
// ctx_stage_tracker: S2..S4 in-flight context records plus issue-time hazard comparators
module ctx_stage_tracker
  import context_hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue,
  input  logic [Q_length-1:0] q,
  output logic                stall,
  output logic                fb,
  output logic                empty,
  output logic                s2_upd,
  output stage_t              s4
);
  stage_t s2, s3;
  logic needs_upd;
  always_comb begin
    needs_upd = s3.valid && q == s3.q && !(s2.valid && q == s2.q);
    stall = (s4.valid && q == s4.q) || (s3.valid && q == s3.q && s2.needs_upd);
    empty = !(s2.valid || s3.valid || s4.valid);
    s2_upd = s2.needs_upd;
  end
  // fb marks an S4 entry whose predecessor in S4 last cycle had the same context
  always_ff @(posedge clk)
    if (!rst_n) begin
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
      fb <= 1'b0;
    end else begin
      s2 <= issue ? stage_t'{1'b1, q, needs_upd} : '0;
      s3 <= s2;
      s4 <= s3;
      fb <= s3.valid && s4.valid && s3.q == s4.q;
    end
endmodule

// File: rtl/context_hazard_ctrl.sv
// context_hazard_ctrl: JPEG-LS context memory init/issue/write-back sequencing; CTX_HAZARD_STATS_EN adds counters
module context_hazard_ctrl
  import context_hazard_ctrl_pkg::*;
(
  input logic clk,
  input logic rst_n,
  context_hazard_ctrl_if.slave bus
`ifdef CTX_HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] fb_cnt,
  output logic [15:0] upd_cnt
`endif
);
  localparam logic [Q_length-1:0] LAST = Q_length'(NUM_CTX - 1);
  state_t state, nxt;
  logic [Q_length-1:0] cnt;
  logic fe_pend, run, stall, fb, empty, s2_upd, issue;
  stage_t s4;
  ctx_stage_tracker u_trk (
    .clk(clk), .rst_n(rst_n), .issue(issue), .q(bus.in_Q),
    .stall(stall), .fb(fb), .empty(empty), .s2_upd(s2_upd), .s4(s4)
  );
  always_comb begin
    run = state == RUN;
    bus.in_ready = run && !stall;
    issue = bus.in_valid && bus.in_ready;
    bus.mem_rd_en = issue;
    bus.mem_rd_addr = bus.in_Q;
    bus.mem_wr_init = state == INIT;
    bus.mem_wr_en = bus.mem_wr_init || s4.valid;
    bus.mem_wr_addr = bus.mem_wr_init ? cnt : s4.q;
    bus.sel_feedback = fb;
    bus.use_updated = s4.valid && s4.needs_upd && !fb;
    bus.upd_capture_en = s4.valid && s2_upd;
    bus.s4_valid = s4.valid;
    bus.busy = state != IDLE;
    bus.done = state == DRAIN && empty;
    nxt = state == IDLE ? (bus.start ? INIT : IDLE)
        : state == INIT ? (cnt == LAST ? RUN : INIT)
        : state == RUN ? (bus.frame_end || fe_pend ? DRAIN : RUN)
        : (empty ? IDLE : DRAIN);
  end
  // frame_end seen during INIT is held until the first RUN cycle
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      fe_pend <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= state == INIT && nxt == INIT ? cnt + 1'b1 : '0;
      fe_pend <= state == INIT && (fe_pend || bus.frame_end);
    end
`ifdef CTX_HAZARD_STATS_EN
  always_ff @(posedge clk)
    if (!rst_n || (state == IDLE && bus.start)) begin
      stall_cnt <= '0;
      fb_cnt <= '0;
      upd_cnt <= '0;
    end else begin
      if (run && bus.in_valid && stall && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (bus.sel_feedback && ~&fb_cnt) fb_cnt <= fb_cnt + 1'b1;
      if (bus.use_updated && ~&upd_cnt) upd_cnt <= upd_cnt + 1'b1;
    end
`endif
endmodule
